// File: rtl/pix_frame_capture.sv
// Captures 28x28 pixel frames from a raster stream into a ping-pong store and
// hands each completed frame to a consumer through a valid/ack handshake.
module pix_frame_capture #(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned IMG_DIM = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       H_cont,
  input  logic [4:0]       V_cont,
  input  logic             start_stream,
  input  logic             start_pixel,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic [9:0]       rd_addr,
  output logic [PIX_W-1:0] rd_data,
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic             frame_drop,
  output logic             sync_err
);

  localparam int unsigned FRAME     = IMG_DIM * IMG_DIM;
  localparam int unsigned MEM_DEPTH = 2 * FRAME;
  localparam int unsigned MA_W      = $clog2(MEM_DEPTH);

  localparam logic [9:0]      LAST_IDX = 10'(FRAME - 1);
  localparam logic [9:0]      DIM_10   = 10'(IMG_DIM);
  localparam logic [4:0]      DIM_5    = 5'(IMG_DIM);
  localparam logic [MA_W-1:0] FRAME_MA = MA_W'(FRAME);

  typedef enum logic [0:0] {
    StWaitSof,
    StCapture
  } state_e;

  state_e     state_q, state_d;
  logic       wr_bank_q, wr_bank_d;
  logic [9:0] expected_q, expected_d;
  logic       frame_valid_q, frame_valid_d;
  logic       frame_drop_q, frame_drop_d;
  logic       sync_err_q, sync_err_d;

  logic       rd_bank;
  logic [9:0] h_off, v_off, idx;
  logic       h_ok, v_ok, in_range;
  logic       wr_en;
  logic [9:0] wr_idx;
  logic       frame_done;

  // The read bank is always the one the writer is not using.
  assign rd_bank = ~wr_bank_q;

  // ---------------------------------------------------------------------------
  // Pixel index and range check
  // ---------------------------------------------------------------------------
  assign h_off    = {5'd0, H_cont} - 10'd1;
  assign v_off    = {5'd0, V_cont} - 10'd1;
  assign idx      = (v_off * DIM_10) + h_off;
  assign h_ok     = (H_cont != 5'd0) && (H_cont <= DIM_5);
  assign v_ok     = (V_cont != 5'd0) && (V_cont <= DIM_5);
  assign in_range = h_ok && v_ok;

  // ---------------------------------------------------------------------------
  // Capture FSM and handoff
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StWaitSof;
      wr_bank_q     <= 1'b0;
      expected_q    <= 10'd0;
      frame_valid_q <= 1'b0;
      frame_drop_q  <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      expected_q    <= expected_d;
      frame_valid_q <= frame_valid_d;
      frame_drop_q  <= frame_drop_d;
      sync_err_q    <= sync_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    expected_d    = expected_q;
    frame_valid_d = frame_valid_q;
    frame_drop_d  = 1'b0;
    sync_err_d    = 1'b0;
    wr_en         = 1'b0;
    wr_idx        = idx;
    frame_done    = 1'b0;

    if (frame_ack && frame_valid_q) begin
      frame_valid_d = 1'b0;
    end

    if (start_stream) begin
      if (!in_range) begin
        sync_err_d = 1'b1;
        expected_d = 10'd0;
        state_d    = StWaitSof;
      end else begin
        unique case (state_q)
          StWaitSof: begin
            if (start_pixel) begin
              wr_en      = 1'b1;
              wr_idx     = 10'd0;
              expected_d = 10'd1;
              state_d    = StCapture;
            end
          end
          StCapture: begin
            if (start_pixel) begin
              // Premature restart: drop the partial frame, keep capturing.
              sync_err_d = 1'b1;
              wr_en      = 1'b1;
              wr_idx     = 10'd0;
              expected_d = 10'd1;
            end else if (idx == expected_q) begin
              wr_en = 1'b1;
              if (idx == LAST_IDX) begin
                frame_done = 1'b1;
                expected_d = 10'd0;
                state_d    = StWaitSof;
              end else begin
                expected_d = expected_q + 10'd1;
              end
            end else begin
              sync_err_d = 1'b1;
              expected_d = 10'd0;
              state_d    = StWaitSof;
            end
          end
          default: begin
            state_d    = StWaitSof;
            expected_d = 10'd0;
          end
        endcase
      end
    end

    // frame_valid_d already reflects a same-cycle ack, so an ack coinciding
    // with completion frees the consumer slot before the swap decision.
    if (frame_done) begin
      if (!frame_valid_d) begin
        wr_bank_d     = ~wr_bank_q;
        frame_valid_d = 1'b1;
      end else begin
        frame_drop_d = 1'b1;
      end
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_drop  = frame_drop_q;
  assign sync_err    = sync_err_q;

  // ---------------------------------------------------------------------------
  // Ping-pong frame store: one write port, one registered read port
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] mem [MEM_DEPTH];
  logic [MA_W-1:0]  wr_ma, rd_ma;
  logic             rd_hit, rd_hit_q;
  logic [PIX_W-1:0] mem_rd_q;

  assign wr_ma  = (wr_bank_q ? FRAME_MA : '0) + MA_W'(wr_idx);
  assign rd_hit = (rd_addr <= LAST_IDX);
  assign rd_ma  = rd_hit ? ((rd_bank ? FRAME_MA : '0) + MA_W'(rd_addr)) : '0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ma] <= pixel_in;
    end
    mem_rd_q <= mem[rd_ma];
  end

  // Out-of-range reads and the reset state are forced to zero at the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_hit_q <= 1'b0;
    end else begin
      rd_hit_q <= rd_hit;
    end
  end

  assign rd_data = rd_hit_q ? mem_rd_q : '0;

endmodule

// File: tb/tb_pix_frame_capture.sv
// Directed self-checking bench for pix_frame_capture: frame capture, handoff,
// overflow, resync, range errors, ack/complete collision and mid-frame reset.
module tb_pix_frame_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] H_cont, V_cont;
  logic       start_stream, start_pixel;
  logic [7:0] pixel_in;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_valid, frame_ack, frame_drop, sync_err;

  int checks = 0;
  int errors = 0;
  int se_cnt = 0;
  int drop_cnt = 0;

  pix_frame_capture #(.PIX_W(8), .IMG_DIM(28)) dut (
    .clk          (clk),
    .reset        (reset),
    .H_cont       (H_cont),
    .V_cont       (V_cont),
    .start_stream (start_stream),
    .start_pixel  (start_pixel),
    .pixel_in     (pixel_in),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_valid  (frame_valid),
    .frame_ack    (frame_ack),
    .frame_drop   (frame_drop),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sync_err === 1'b1) se_cnt++;
    if (frame_drop === 1'b1) drop_cnt++;
  end

  task automatic strobe(input int h, input int v, input logic [7:0] p);
    H_cont       = 5'(h);
    V_cont       = 5'(v);
    pixel_in     = p;
    start_pixel  = (h == 1 && v == 1);
    start_stream = 1'b1;
    @(negedge clk);
    start_stream = 1'b0;
    start_pixel  = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input bit inv);
    for (int i = first; i <= last; i++) begin
      strobe(i % 28 + 1, i / 28 + 1, inv ? 8'(255 - (i % 256)) : 8'(i));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read(input int a, output logic [7:0] d);
    rd_addr = 10'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    idle(2);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_fv got %b want 0", frame_valid); end
    checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL rst_drop got %b want 0", frame_drop); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", sync_err); end
    checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL rst_rd got %0d want 0", rd_data); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_full_frame();
    logic [7:0] d;
    int base;
    base = se_cnt;
    send_range(0, 782, 1'b0);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL full_fv_early got %b want 0", frame_valid); end
    send_range(783, 783, 1'b0);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL full_fv got %b want 1", frame_valid); end
    read(0, d);
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL full_rd0 got %0d want 0", d); end
    read(27, d);
    checks++; if (d !== 8'd27) begin errors++; $display("FAIL full_rd27 got %0d want 27", d); end
    read(28, d);
    checks++; if (d !== 8'd28) begin errors++; $display("FAIL full_rd28 got %0d want 28", d); end
    read(783, d);
    checks++; if (d !== 8'd15) begin errors++; $display("FAIL full_rd783 got %0d want 15", d); end
    read(800, d);
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL full_rd800 got %0d want 0", d); end
    checks++; if (se_cnt - base !== 0) begin errors++; $display("FAIL full_syncerr got %0d want 0", se_cnt - base); end
  endtask

  task automatic test_two_frames();
    logic [7:0] d;
    int base;
    base = drop_cnt;
    ack();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL two_fv_ack got %b want 0", frame_valid); end
    send_range(0, 783, 1'b1);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL two_fv got %b want 1", frame_valid); end
    read(5, d);
    checks++; if (d !== 8'd250) begin errors++; $display("FAIL two_rd5 got %0d want 250", d); end
    read(783, d);
    checks++; if (d !== 8'd240) begin errors++; $display("FAIL two_rd783 got %0d want 240", d); end
    idle(1);
    checks++; if (drop_cnt - base !== 0) begin errors++; $display("FAIL two_drop got %0d want 0", drop_cnt - base); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    ack();
    send_range(0, 783, 1'b0);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ovf_fv1 got %b want 1", frame_valid); end
    send_range(0, 783, 1'b1);
    checks++; if (frame_drop !== 1'b1) begin errors++; $display("FAIL ovf_drop got %b want 1", frame_drop); end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ovf_fv got %b want 1", frame_valid); end
    read(5, d);
    checks++; if (d !== 8'd5) begin errors++; $display("FAIL ovf_rd5 got %0d want 5", d); end
    checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL ovf_drop_pulse got %b want 0", frame_drop); end
    read(783, d);
    checks++; if (d !== 8'd15) begin errors++; $display("FAIL ovf_rd783 got %0d want 15", d); end
  endtask

  task automatic test_resync();
    logic [7:0] d;
    int base;
    ack();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rsy_fv_ack got %b want 0", frame_valid); end
    base = se_cnt;
    send_range(0, 64, 1'b0);
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL rsy_err_early got %b want 0", sync_err); end
    strobe(11, 3, 8'h11);
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL rsy_err got %b want 1", sync_err); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rsy_fv0 got %b want 0", frame_valid); end
    send_range(0, 783, 1'b1);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL rsy_fv got %b want 1", frame_valid); end
    read(100, d);
    checks++; if (d !== 8'd155) begin errors++; $display("FAIL rsy_rd100 got %0d want 155", d); end
    checks++; if (se_cnt - base !== 1) begin errors++; $display("FAIL rsy_errcnt got %0d want 1", se_cnt - base); end
  endtask

  task automatic test_restart_range();
    logic [7:0] d;
    int base;
    ack();
    send_range(0, 99, 1'b0);
    strobe(1, 1, 8'hAA);
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL rst1_err got %b want 1", sync_err); end
    send_range(1, 783, 1'b0);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL rst1_fv got %b want 1", frame_valid); end
    read(0, d);
    checks++; if (d !== 8'hAA) begin errors++; $display("FAIL rst1_rd0 got %0d want 170", d); end
    read(99, d);
    checks++; if (d !== 8'd99) begin errors++; $display("FAIL rst1_rd99 got %0d want 99", d); end
    read(783, d);
    checks++; if (d !== 8'd15) begin errors++; $display("FAIL rst1_rd783 got %0d want 15", d); end
    ack();
    base = se_cnt;
    strobe(1, 1, 8'd1);
    strobe(2, 1, 8'd2);
    strobe(0, 1, 8'h77);
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL h0_err got %b want 1", sync_err); end
    strobe(5, 1, 8'd5);
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL h0_waitsof got %b want 0", sync_err); end
    read(239, d);
    checks++; if (d !== 8'd239) begin errors++; $display("FAIL h0_nowrite got %0d want 239", d); end
    strobe(1, 1, 8'd1);
    strobe(29, 1, 8'h77);
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL h29_err got %b want 1", sync_err); end
    strobe(5, 1, 8'd5);
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL h29_waitsof got %b want 0", sync_err); end
    checks++; if (se_cnt - base !== 2) begin errors++; $display("FAIL range_errcnt got %0d want 2", se_cnt - base); end
    send_range(0, 783, 1'b1);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL range_fv got %b want 1", frame_valid); end
    read(2, d);
    checks++; if (d !== 8'd253) begin errors++; $display("FAIL range_rd2 got %0d want 253", d); end
  endtask

  task automatic test_ack_collision();
    logic [7:0] d;
    int base;
    ack();
    send_range(0, 783, 1'b0);
    base = drop_cnt;
    send_range(0, 782, 1'b1);
    frame_ack = 1'b1;
    strobe(28, 28, 8'd240);
    frame_ack = 1'b0;
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL coll_fv got %b want 1", frame_valid); end
    checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL coll_drop got %b want 0", frame_drop); end
    read(5, d);
    checks++; if (d !== 8'd250) begin errors++; $display("FAIL coll_rd5 got %0d want 250", d); end
    idle(1);
    checks++; if (drop_cnt - base !== 0) begin errors++; $display("FAIL coll_dropcnt got %0d want 0", drop_cnt - base); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    send_range(0, 299, 1'b0);
    reset = 1'b1;
    #2;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL mrst_fv got %b want 0", frame_valid); end
    checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL mrst_drop got %b want 0", frame_drop); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL mrst_err got %b want 0", sync_err); end
    checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL mrst_rd got %0d want 0", rd_data); end
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    send_range(0, 783, 1'b0);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL mrst_fv_new got %b want 1", frame_valid); end
    read(27, d);
    checks++; if (d !== 8'd27) begin errors++; $display("FAIL mrst_rd27 got %0d want 27", d); end
    read(783, d);
    checks++; if (d !== 8'd15) begin errors++; $display("FAIL mrst_rd783 got %0d want 15", d); end
  endtask

  initial begin
    reset        = 1'b1;
    H_cont       = 5'd0;
    V_cont       = 5'd0;
    start_stream = 1'b0;
    start_pixel  = 1'b0;
    pixel_in     = 8'd0;
    rd_addr      = 10'd0;
    frame_ack    = 1'b0;
    test_reset();
    test_full_frame();
    test_two_frames();
    test_overflow();
    test_resync();
    test_restart_range();
    test_ack_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
